dmem_arbiter: RTL and testbench

//   Shares the single data-memory port (RAM + memory-mapped switches/LEDs) between the

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three sides of the data-memory arbiter into one interface:
//   the CPU MEM-stage port (cpu_*), the secondary DMA/loader port (dma_*)
//   and the shared data-memory port (mem_*).
//   Modports:
//     slave  : the arbiter. It serves the CPU and DMA requests and drives dmem.
//     master : the environment. It issues CPU/DMA requests and returns mem_rd.
interface dmem_arbiter_if;
    // CPU (priority master)
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_a;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    // DMA / loader (secondary master)
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_a;
    logic [31:0] dma_wd;
    logic [31:0] dma_rd;
    logic        dma_ack;
    // Shared data-memory port
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_wd,
        input  dma_req, dma_we, dma_a, dma_wd,
        input  mem_rd,
        output cpu_rd, cpu_stall,
        output dma_rd, dma_ack,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_wd,
        output dma_req, dma_we, dma_a, dma_wd,
        output mem_rd,
        input  cpu_rd, cpu_stall,
        input  dma_rd, dma_ack,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port (RAM plus memory-mapped switches/LEDs)
//   between the pipeline MEM stage (CPU, priority master) and a DMA/loader.
//   The CPU wins by default; after MAX_WAIT consecutive denied DMA-request
//   cycles the DMA is forced in for one cycle, stalling the CPU for that cycle.
//   Memory reads are combinational, writes commit on posedge clk in dmem.
// Parameters
//   MAX_WAIT : denied DMA-request cycles before the DMA is forced in (1..255)
//   CNT_W    : starvation counter width, must be able to hold MAX_WAIT
// Ports
//   clk      : system clock, all state updates on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : dmem_arbiter_if.slave (cpu_*, dma_*, mem_* signal groups)
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_arbiter_if.slave    bus
);

    typedef enum logic {
        ARB = 1'b0,   // arbitration cycle, DMA may be granted
        ACK = 1'b1    // DMA completion cycle, CPU owns the port
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             starved;
    logic             grant_dma;
    logic [31:0]      dma_rd_q;

    assign starved = (wait_cnt == WAIT_LIMIT);

    // Read data for the CPU is always the raw memory read; the CPU only
    // consumes it in cycles where cpu_stall is low.
    assign bus.cpu_rd = bus.mem_rd;
    assign bus.dma_rd = dma_rd_q;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        grant_dma    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_a     = bus.cpu_a;
        bus.mem_wd    = bus.cpu_wd;
        bus.cpu_stall = 1'b0;
        bus.dma_ack   = 1'b0;

        unique case (state)
            ARB: begin
                // Gating with reset_n keeps a pending DMA off the port while
                // reset is held, so an in-flight grant aborts immediately.
                grant_dma = reset_n & bus.dma_req & (~bus.cpu_req | starved);
                if (grant_dma) begin
                    bus.mem_we    = bus.dma_we;
                    bus.mem_a     = bus.dma_a;
                    bus.mem_wd    = bus.dma_wd;
                    bus.cpu_stall = bus.cpu_req;
                    wait_cnt_nxt  = '0;
                    state_nxt     = ACK;
                end else begin
                    bus.mem_we = bus.cpu_we & bus.cpu_req;
                    if (bus.dma_req) begin
                        // Saturate so a long CPU burst cannot wrap the counter.
                        wait_cnt_nxt = starved ? wait_cnt : wait_cnt + CNT_W'(1);
                    end else begin
                        wait_cnt_nxt = '0;
                    end
                end
            end
            ACK: begin
                // DMA request seen here is ignored; it only starts counting
                // from the following ARB cycle.
                bus.dma_ack  = 1'b1;
                bus.mem_we   = bus.cpu_we & bus.cpu_req;
                wait_cnt_nxt = '0;
                state_nxt    = ARB;
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB;
            wait_cnt <= '0;
            dma_rd_q <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (grant_dma) begin
                dma_rd_q <= bus.mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. Contains a small dmem model
//   (64-word RAM, switches at 0xC000_0000, LEDs at 0xC000_0004).
//   Expected DMA read data is queued when a DMA request is issued and
//   compared when dma_ack is observed.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam logic [31:0] SWITCHES = 32'h0000_0ABC;

    logic clk;
    logic reset_n;
    logic preload;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dmem model ----------------
    logic [31:0] ram [0:63];
    logic [31:0] leds;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 2) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
    endfunction

    always_comb begin
        if (bus.mem_a == 32'hC000_0000)      bus.mem_rd = SWITCHES;
        else if (bus.mem_a == 32'hC000_0004) bus.mem_rd = leds;
        else                                 bus.mem_rd = ram[bus.mem_a[7:2]];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            leds <= '0;
        end else if (bus.mem_we) begin
            if (bus.mem_a == 32'hC000_0004)    leds <= bus.mem_wd;
            else if (bus.mem_a[31:8] == 24'h0) ram[bus.mem_a[7:2]] <= bus.mem_wd;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard monitor plus protocol invariants: no back-to-back acks,
    // no back-to-back stalls.
    logic prev_ack   = 1'b0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.dma_ack) begin
                check_eq("ack_gap", 32'(prev_ack), 32'd0);
                if (exp_q.size() == 0) check_eq("ack_unexpected", 32'(bus.dma_ack), 32'd0);
                else                   check_eq("dma_rd", bus.dma_rd, exp_q.pop_front());
            end
            if (bus.cpu_stall) check_eq("stall_gap", 32'(prev_stall), 32'd0);
        end
        prev_ack   = reset_n & bus.dma_ack;
        prev_stall = reset_n & bus.cpu_stall;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_wd = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_a = '0; bus.dma_wd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old_word;
        logic [31:0] b2b_addr [3];
        b2b_addr[0] = 32'h14; b2b_addr[1] = 32'h18; b2b_addr[2] = 32'h1C;

        idle_inputs();
        reset_n = 1'b0;
        preload = 1'b1;

        // ---- 1. reset with requests active ----
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 32'h3C;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_a = 32'h30;
        @(negedge clk);
        check_eq("rst_ack",   32'(bus.dma_ack),   32'd0);
        check_eq("rst_rd",    bus.dma_rd,         32'd0);
        check_eq("rst_stall", 32'(bus.cpu_stall), 32'd0);
        check_eq("rst_we",    32'(bus.mem_we),    32'd0);
        step();
        bus.cpu_we = 1'b1;
        @(negedge clk);
        check_eq("rst_we_cpu", 32'(bus.mem_we), 32'd1);
        check_eq("rst_mem_a",  bus.mem_a,       32'h3C);
        step();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_eq("rst_we_dma",    32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_a_dma", bus.mem_a,       32'h3C);
        step();
        idle_inputs();
        preload = 1'b0;
        reset_n = 1'b1;
        step();

        // ---- 2. DMA alone reads RAM[2] ----
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = 32'h08;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("dma_mem_a",   bus.mem_a,          32'h08);
        check_eq("dma_mem_we",  32'(bus.mem_we),    32'd0);
        check_eq("dma_no_ack",  32'(bus.dma_ack),   32'd0);
        check_eq("dma_nostall", 32'(bus.cpu_stall), 32'd0);
        step();
        check_eq("dma_ack", 32'(bus.dma_ack), 32'd1);
        bus.dma_req = 1'b0;
        step();

        // ---- 3. CPU priority and starvation forcing ----
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 32'h20;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = 32'h0C;
        exp_q.push_back(init_word(3));
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            if (c == 5) bus.dma_req = 1'b0;
            @(negedge clk);
            check_eq("prio_stall", 32'(bus.cpu_stall), 32'(c == 4));
            check_eq("prio_mem_a", bus.mem_a, (c == 4) ? 32'h0C : 32'h20);
            check_eq("prio_ack",   32'(bus.dma_ack),   32'(c == 5));
            if (c != 4) check_eq("prio_cpu_rd", bus.cpu_rd, init_word(8));
        end
        step();
        idle_inputs();
        step();

        // ---- 4. write paths: CPU to LEDs, DMA to RAM[4] ----
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 32'hC000_0004; bus.cpu_wd = 32'h3FF;
        @(negedge clk);
        check_eq("cpu_wr_we", 32'(bus.mem_we), 32'd1);
        step();
        check_eq("leds", leds, 32'h3FF);
        idle_inputs();
        old_word = ram[4];
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_a = 32'h10; bus.dma_wd = 32'h55;
        exp_q.push_back(old_word);
        @(negedge clk);
        check_eq("dma_wr_we", 32'(bus.mem_we), 32'd1);
        check_eq("dma_wr_a",  bus.mem_a,       32'h10);
        check_eq("dma_wr_wd", bus.mem_wd,      32'h55);
        step();
        check_eq("ram4",       ram[4],          32'h55);
        check_eq("dma_wr_ack", 32'(bus.dma_ack), 32'd1);
        bus.dma_req = 1'b0;
        step();

        // ---- 5. back-to-back DMA reads, CPU idle ----
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            if (c % 2 == 0) begin
                bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = b2b_addr[c / 2];
                exp_q.push_back(ram[b2b_addr[c / 2][7:2]]);
            end
            @(negedge clk);
            check_eq("b2b_ack", 32'(bus.dma_ack), 32'(c % 2));
            if (c % 2 == 0) check_eq("b2b_mem_a", bus.mem_a, b2b_addr[c / 2]);
        end
        step();
        bus.dma_req = 1'b0;
        step();

        // ---- 6a. reset during ACK: ack drops at once, write already committed ----
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_a = 32'h24; bus.dma_wd = 32'h77;
        step();
        check_eq("abort_ack_hi", 32'(bus.dma_ack), 32'd1);
        bus.dma_req = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("abort_ack_async", 32'(bus.dma_ack), 32'd0);
        check_eq("abort_rd",        bus.dma_rd,       32'd0);
        check_eq("abort_ram9",      ram[9],           32'h77);
        step();
        reset_n = 1'b1;
        step();

        // ---- 6b. reset clears a partly built starvation count ----
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 32'h20;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = 32'h28;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            @(negedge clk);
            check_eq("pre_rst_stall", 32'(bus.cpu_stall), 32'd0);
        end
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q.push_back(init_word(10));
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            if (c == 5) bus.dma_req = 1'b0;
            @(negedge clk);
            check_eq("post_rst_stall", 32'(bus.cpu_stall), 32'(c == 4));
            check_eq("post_rst_ack",   32'(bus.dma_ack),   32'(c == 5));
        end
        step();
        idle_inputs();
        step();
        step();

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
